// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// holds the returned instruction for the decoder and applies branch/jump redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic [31:0] ex_pc_plus4,
    input  logic [31:0] branch_imm,
    input  logic [25:0] jump_index,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [5:0]  opcode
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;

    logic        w_redir;
    logic [31:0] w_off;
    logic [31:0] w_tgt;

    assign w_redir = jump | (branch & alu_zero);
    assign w_off   = branch_imm << 2;
    assign w_tgt   = jump ? {ex_pc_plus4[31:28], jump_index, 2'b00}
                          : ex_pc_plus4 + w_off;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_redir) begin
                        r_pc <= w_tgt;
                    end else if (enable) begin
                        r_addr  <= r_pc;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        if (w_redir) begin
                            // Stale word: reissue straight at the target.
                            r_pc   <= w_tgt;
                            r_addr <= w_tgt;
                        end else begin
                            r_instr    <= imem_rdata;
                            r_instr_pc <= r_addr;
                            r_valid    <= 1'b1;
                            r_pc       <= r_addr + 32'd4;
                            r_req      <= 1'b0;
                            r_state    <= HOLD;
                        end
                    end else if (w_redir) begin
                        r_pc    <= w_tgt;
                        r_state <= DISCARD;
                    end
                end
                HOLD: begin
                    if (w_redir) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_tgt;
                        r_state <= IDLE;
                    end else if (!stall) begin
                        r_valid <= 1'b0;
                        if (enable) begin
                            r_addr  <= r_pc;
                            r_req   <= 1'b1;
                            r_state <= FETCH;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (w_redir) begin
                        r_pc <= w_tgt;
                    end
                    if (imem_rvalid) begin
                        r_addr  <= w_redir ? w_tgt : r_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign opcode      = r_instr[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic
// checked against an in-order handover model with a variable-latency memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        alu_zero;
    logic        jump;
    logic [31:0] ex_pc_plus4;
    logic [31:0] branch_imm;
    logic [25:0] jump_index;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [5:0]  opcode;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .jump        (jump),
        .ex_pc_plus4 (ex_pc_plus4),
        .branch_imm  (branch_imm),
        .jump_index  (jump_index),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .opcode      (opcode)
    );

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 1;
    bit rand_lat = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_ctl();
        branch      = 1'b0;
        alu_zero    = 1'b0;
        jump        = 1'b0;
        ex_pc_plus4 = '0;
        branch_imm  = '0;
        jump_index  = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        if (!instr_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    // Memory responder: answers no earlier than the second request cycle.
    initial begin
        int          cnt;
        logic        p_req;
        logic [31:0] p_addr;
        cnt = 0;
        p_req = 1'b0;
        p_addr = '0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                imem_rvalid = 1'b0;
                cnt = 0;
                p_req = 1'b0;
            end else begin
                if (p_req && !imem_rvalid && imem_req)
                    chk("addr_stable", imem_addr, p_addr);
                if (imem_rvalid) begin
                    imem_rvalid = 1'b0;
                    cnt = imem_req ? 1 : 0;
                    if (rand_lat) mem_lat = $urandom_range(1, 4);
                end else if (imem_req) begin
                    if (cnt >= mem_lat) begin
                        imem_rvalid = 1'b1;
                        imem_rdata = memf(imem_addr);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
                p_req = imem_req;
                p_addr = imem_addr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          consumed;
        logic [31:0] m_next;
        logic [31:0] tgt;
        logic        redir;
        int          k;

        arst_n = 1'b0;
        enable = 1'b0;
        stall  = 1'b1;
        clr_ctl();
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_opc", 32'(opcode), 32'd0);

        enable = 1'b1;
        arst_n = 1'b1;
        step();
        chk("f0_req", 32'(imem_req), 32'd1);
        chk("f0_addr", imem_addr, 32'h0);
        wait_valid(n);
        chk("f0_lat", 32'(n), 32'd2);
        chk("f0_instr", instr, 32'h2008_0005);
        chk("f0_opc", 32'(opcode), 32'h08);
        chk("f0_ipc", instr_pc, 32'h0);
        chk("f0_reqlo", 32'(imem_req), 32'd0);

        repeat (4) begin
            step();
            chk("stl_valid", 32'(instr_valid), 32'd1);
            chk("stl_instr", instr, 32'h2008_0005);
            chk("stl_ipc", instr_pc, 32'h0);
            chk("stl_req", 32'(imem_req), 32'd0);
        end

        stall = 1'b0;
        step();
        stall = 1'b1;
        chk("f1_req", 32'(imem_req), 32'd1);
        chk("f1_addr", imem_addr, 32'h4);
        chk("f1_vlo", 32'(instr_valid), 32'd0);
        wait_valid(n);
        chk("f1_thru", 32'(n + 1), 32'd3);
        chk("f1_ipc", instr_pc, 32'h4);
        chk("f1_instr", instr, memf(32'h4));

        branch = 1'b1;
        alu_zero = 1'b1;
        ex_pc_plus4 = 32'h40;
        branch_imm = 32'hFFFF_FFFE;
        step();
        clr_ctl();
        chk("br_flush", 32'(instr_valid), 32'd0);
        chk("br_req", 32'(imem_req), 32'd0);
        step();
        chk("br_addr", imem_addr, 32'h38);
        chk("br_req1", 32'(imem_req), 32'd1);
        wait_valid(n);
        chk("br_ipc", instr_pc, 32'h38);

        mem_lat = 3;
        stall = 1'b0;
        step();
        stall = 1'b1;
        chk("jf_addr", imem_addr, 32'h3C);
        jump = 1'b1;
        ex_pc_plus4 = 32'h1000_0010;
        jump_index = 26'h40;
        step();
        clr_ctl();
        chk("jf_old", imem_addr, 32'h3C);
        chk("jf_vlo", 32'(instr_valid), 32'd0);
        wait_valid(n);
        chk("jf_ipc", instr_pc, 32'h1000_0100);
        chk("jf_instr", instr, memf(32'h1000_0100));

        mem_lat = 1;
        branch = 1'b1;
        alu_zero = 1'b0;
        ex_pc_plus4 = 32'h80;
        branch_imm = 32'h5;
        stall = 1'b0;
        step();
        clr_ctl();
        stall = 1'b1;
        chk("nt_addr", imem_addr, 32'h1000_0104);
        wait_valid(n);
        chk("nt_ipc", instr_pc, 32'h1000_0104);

        jump = 1'b1;
        ex_pc_plus4 = 32'hF000_0000;
        jump_index = 26'h3FF_FFFF;
        step();
        clr_ctl();
        step();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(n);
        chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);
        mem_lat = 3;
        stall = 1'b0;
        step();
        stall = 1'b1;
        chk("wr_next", imem_addr, 32'h0);
        chk("wr_req", 32'(imem_req), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        step();
        mem_lat = 1;
        arst_n = 1'b1;
        wait_valid(n);
        chk("ar_lat", 32'(n), 32'd3);
        chk("ar_ipc", instr_pc, 32'h0);
        chk("ar_instr", instr, 32'h2008_0005);

        // Random traffic: every handed-over word must follow the program order
        // implied by sequential flow and the most recent redirect.
        rand_lat = 1'b1;
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        m_next = 32'h0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            enable = ($urandom % 10) != 0;
            stall  = ($urandom % 10) < 3;
            k = int'($urandom % 16);
            ex_pc_plus4 = $urandom & 32'hFFFF_FFFC;
            branch_imm  = 32'($urandom_range(0, 1023)) - 32'd512;
            jump_index  = 26'($urandom);
            jump     = (k == 0);
            branch   = (k == 1) || (k == 2) || ((k == 0) && $urandom_range(0, 1) == 1);
            alu_zero = (k == 1) || ((k == 0) && $urandom_range(0, 1) == 1);
            redir = jump || (branch && alu_zero);
            if (jump)
                tgt = (ex_pc_plus4 & 32'hF000_0000) + 32'(jump_index) * 32'd4;
            else
                tgt = ex_pc_plus4 + branch_imm * 32'd4;
            if (instr_valid && !stall && !redir) begin
                chk("rnd_ipc", instr_pc, m_next);
                chk("rnd_instr", instr, memf(m_next));
                chk("rnd_opc", 32'(opcode), memf(m_next) >> 26);
                m_next = m_next + 32'd4;
                consumed++;
            end
            if (redir) m_next = tgt;
        end
        clr_ctl();
        rand_lat = 1'b0;
        chk("rnd_progress", 32'(consumed >= 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the main control decoder.
- Owns the program counter and issues one outstanding request at a time to instruction memory, which has variable latency.
- Holds the returned instruction in an output register. Its opcode field drives the control decoder.
- Consumes the decoder's branch/jump decisions (plus ALU zero) to redirect the PC and flush a stale instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits starting new fetches.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request word address (byte address, bits[1:0]=0).
- imem_rvalid  input  1  response valid.
- imem_rdata  input  32  response instruction word.
- stall  input  1  downstream not accepting the held instruction.
- branch  input  1  from control unit; conditional branch.
- alu_zero  input  1  ALU zero flag for the branch.
- jump  input  1  from control unit; unconditional jump.
- ex_pc_plus4  input  32  PC+4 of the resolving branch/jump instruction.
- branch_imm  input  32  sign-extended 16-bit branch offset, in words.
- jump_index  input  26  jump target index field.
- instr  output  32  held instruction.
- instr_pc  output  32  address of the held instruction.
- instr_valid  output  1  held instruction valid.
- opcode  output  6  instr[31:26]; feeds control unit.

Behaviour:
- Reset (arst_n=0, async), all registered state:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr=0, instr_pc=0, instr_valid=0; opcode therefore 0.
- Redirect condition: redir = jump | (branch & alu_zero).
- Redirect target:
  - jump has priority: tgt = {ex_pc_plus4[31:28], jump_index, 2'b00}.
  - otherwise tgt = ex_pc_plus4 + (branch_imm << 2), mod 2^32.
- PC increment: pc+4, wraps 32'hFFFF_FFFC -> 0.
- Handover: an instruction is consumed in a cycle with instr_valid=1 and stall=0.
- imem protocol:
  - imem_req is held at 1 with a stable imem_addr until imem_rvalid=1.
  - imem_rvalid is only sampled while imem_req=1.
  - Earliest response is the cycle after req rises; imem_req drops the cycle after the response.
- IDLE:
  - imem_req=0.
  - redir: pc<=tgt, stay IDLE.
  - else if enable: imem_addr<=pc, imem_req<=1, -> FETCH.
- FETCH:
  - rvalid & !redir: instr<=rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=imem_addr+4, req<=0, -> HOLD.
  - rvalid & redir: drop rdata; pc<=tgt, imem_addr<=tgt, req stays 1, stay FETCH. instr_valid unchanged (0).
  - !rvalid & redir: pc<=tgt, -> DISCARD. Request continues on the old address.
  - !rvalid & !redir: wait.
- HOLD:
  - redir has priority over the stall check: instr_valid<=0 (flush), pc<=tgt, -> IDLE.
  - !stall: instr_valid<=0.
    - enable: imem_addr<=pc, req<=1, -> FETCH.
    - else -> IDLE.
  - stall: hold all outputs.
- DISCARD:
  - rvalid: drop data, imem_addr<=pc, req stays 1, -> FETCH.
  - redir while in DISCARD: pc<=tgt (latest redirect wins).
- Throughput and latency:
  - instr_valid rises the cycle after rvalid.
  - Back-to-back with a 1-cycle memory: one instruction per 3 cycles.
- enable=0 never aborts an in-flight request; it only blocks new ones.
- Reset mid-request: imem_req drops asynchronously. The memory must tolerate the abandoned request.
- opcode is combinational from instr, with no further latency.

Test Plan:
- Reset release, enable=1, memory returns 32'h2008_0005 one cycle after req:
  - imem_addr=0, instr_valid=1, opcode=6'h08, instr_pc=0.
  - next request at imem_addr=4 the cycle after consume.
- stall held 4 cycles in HOLD:
  - instr, instr_pc and instr_valid stable; imem_req=0.
  - release -> next req at pc+4.
- In HOLD, branch=1, alu_zero=1, ex_pc_plus4=32'h40, branch_imm=32'hFFFF_FFFE:
  - instr_valid->0.
  - next fetch address 32'h38.
- Redirect in FETCH with memory latency 3, jump=1, ex_pc_plus4=32'h1000_0010, jump_index=26'h40:
  - old response dropped, never made valid.
  - next imem_addr=32'h1000_0100.
- branch=1, alu_zero=0 during HOLD: no redirect; sequential fetch continues.
- Wrap and reset:
  - pc=32'hFFFF_FFFC fetch -> next imem_addr=0.
  - arst_n low mid-FETCH -> imem_req and instr_valid 0 immediately; restart at RESET_PC.
